// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA mode scheduler slice.
package vga_pkg;

  localparam int unsigned MODE_W  = 3;
  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StPend  = 2'd1;
  localparam state_t StBlank = 2'd2;

  // Defaults sized for a 25 MHz pixel clock at 60 Hz.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_AUTO_FRAMES     = 120;
  localparam int unsigned DEF_MODE_COUNT      = 8;
  localparam int unsigned DEF_BLANK_FRAMES    = 1;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_debounce.sv
// Two-flop synchroniser followed by a stable-count filter; the output only
// follows the input after it has held one value for Cycles clocks.
module vga_debounce
  import vga_pkg::*;
#(
  parameter int unsigned Width  = MODE_W,
  parameter int unsigned Cycles = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  localparam int unsigned     CntW   = cnt_w(Cycles);
  localparam logic [CntW-1:0] CntMax = CntW'(Cycles - 1);

  logic [Width-1:0] sync1_q, sync2_q;
  logic [Width-1:0] cand_d, cand_q;
  logic [Width-1:0] deb_d, deb_q;
  logic [CntW-1:0]  cnt_d, cnt_q;

  // Candidate tracking: any change restarts the stability count; the count
  // saturates so it never wraps while the input is idle.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (cnt_d == CntMax) begin
      deb_d = cand_d;
    end
  end

  // Synchroniser and filter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/vga_mode_scheduler.sv
// Applies pattern-mode changes only at frame boundaries, with optional
// auto-cycling and forced black frames around each change.
module vga_mode_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned AUTO_FRAMES     = DEF_AUTO_FRAMES,
  parameter int unsigned MODE_COUNT      = DEF_MODE_COUNT,
  parameter int unsigned BLANK_FRAMES    = DEF_BLANK_FRAMES,
  parameter bit          VS_ACTIVE_LOW   = 1'b1
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic [MODE_W-1:0] switch,
  input  logic              auto_en,
  input  logic              vga_vs,
  output logic [MODE_W-1:0] mode,
  output logic              blank,
  output logic              mode_changed
);

  localparam logic              VsIdle   = VS_ACTIVE_LOW;
  localparam int unsigned       FcntW    = cnt_w(AUTO_FRAMES);
  localparam int unsigned       BcntW    = cnt_w(BLANK_FRAMES + 1);
  localparam logic [FcntW-1:0]  FcntLast = FcntW'(AUTO_FRAMES - 1);
  localparam logic [BcntW-1:0]  BcntLast = BcntW'((BLANK_FRAMES == 0) ? 0 : BLANK_FRAMES - 1);
  localparam logic [MODE_W-1:0] ModeLast = MODE_W'(MODE_COUNT - 1);

  logic              vs_s1_q, vs_s2_q, vs_s3_q;
  logic              fb_d, fb_q;
  logic              auto_s1_q, auto_s2_q;
  logic [MODE_W-1:0] deb, deb_prev_q;

  state_t            state_d, state_q;
  logic [MODE_W-1:0] tgt_d, tgt_q;
  logic [MODE_W-1:0] mode_d, mode_q;
  logic              pend_d, pend_q;
  logic              blank_d, blank_q;
  logic              mc_d, mc_q;
  logic [FcntW-1:0]  fcnt_d, fcnt_q;
  logic [BcntW-1:0]  bcnt_d, bcnt_q;

  logic              man_req, auto_req, req, pend_valid;
  logic [MODE_W-1:0] man_tgt, auto_tgt, req_tgt;

  vga_debounce #(
    .Width  (MODE_W),
    .Cycles (DEBOUNCE_CYCLES)
  ) u_switch_deb (
    .clk  (vga_clk),
    .rst  (sys_rst),
    .din  (switch),
    .dout (deb)
  );

  // Frame boundary: synced vsync has just entered its active level.
  always_comb begin
    fb_d = (vs_s2_q != VsIdle) && (vs_s3_q == VsIdle);
  end

  // Synchronisers, vsync edge register and debounced-value history.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_s1_q    <= VsIdle;
      vs_s2_q    <= VsIdle;
      vs_s3_q    <= VsIdle;
      fb_q       <= 1'b0;
      auto_s1_q  <= 1'b0;
      auto_s2_q  <= 1'b0;
      deb_prev_q <= '0;
    end else begin
      vs_s1_q    <= vga_vs;
      vs_s2_q    <= vs_s1_q;
      vs_s3_q    <= vs_s2_q;
      fb_q       <= fb_d;
      auto_s1_q  <= auto_en;
      auto_s2_q  <= auto_s1_q;
      deb_prev_q <= deb;
    end
  end

  // Request arbitration: manual beats auto; a request that would change
  // nothing (already the mode, or already pending) is dropped.
  always_comb begin
    man_req    = (deb != deb_prev_q);
    man_tgt    = (deb > ModeLast) ? ModeLast : deb;
    auto_tgt   = (mode_q == ModeLast) ? '0 : mode_q + MODE_W'(1);
    auto_req   = (state_q == StIdle) && auto_s2_q && fb_q && (fcnt_q == FcntLast);
    req_tgt    = man_req ? man_tgt : auto_tgt;
    pend_valid = (state_q == StPend) || ((state_q == StBlank) && pend_q);
    req        = (man_req || auto_req) && (req_tgt != mode_q) &&
                 !(pend_valid && (req_tgt == tgt_q));
  end

  // Mode FSM: latch target, apply at the next boundary, then hold black.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    mc_d    = 1'b0;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          tgt_d   = req_tgt;
          state_d = StPend;
        end
      end
      StPend: begin
        if (fb_q) begin
          // A request landing on the boundary cycle is the latest one.
          mode_d = req ? req_tgt : tgt_q;
          mc_d   = 1'b1;
          if (BLANK_FRAMES > 0) begin
            blank_d = 1'b1;
            bcnt_d  = '0;
            pend_d  = 1'b0;
            state_d = StBlank;
          end else begin
            state_d = StIdle;
          end
        end else if (req) begin
          tgt_d = req_tgt;
        end
      end
      StBlank: begin
        if (req) begin
          tgt_d  = req_tgt;
          pend_d = 1'b1;
        end
        if (fb_q) begin
          if (bcnt_q == BcntLast) begin
            blank_d = 1'b0;
            pend_d  = 1'b0;
            state_d = (pend_q || req) ? StPend : StIdle;
          end else begin
            bcnt_d = bcnt_q + BcntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Auto-cycle frame counter; saturates until the resulting change clears it.
  always_comb begin
    fcnt_d = fcnt_q;
    if (!auto_s2_q || mc_d) begin
      fcnt_d = '0;
    end else if (fb_q && (fcnt_q != FcntLast)) begin
      fcnt_d = fcnt_q + FcntW'(1);
    end
  end

  // FSM, output and counter registers.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      mode_q  <= '0;
      blank_q <= 1'b0;
      mc_q    <= 1'b0;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      mc_q    <= mc_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign mode         = mode_q;
  assign blank        = blank_q;
  assign mode_changed = mc_q;

endmodule
